// File: rtl/child_rr_arbiter.sv
// Round-robin arbiter granting one shared slot to NUM_REQ child requesters.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module child_rr_arbiter #(
    parameter int NUM_REQ  = 5,
    parameter int MAX_HOLD = 16,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id,
    output logic               busy,
    output logic               timeout_pulse
);

    localparam int CW = IDW + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
        $error("child_rr_arbiter: NUM_REQ or MAX_HOLD out of range");
    end

    state_t             state, state_n;
    logic [IDW-1:0]     ptr, ptr_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [IDW-1:0]     grant_id_n;
    logic [IDW-1:0]     sel;
    logic [CW-1:0]      cand;
    logic               found;
    logic               normal_rel;
    logic               timeout_hit;

    // Rotating priority search: first requester at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDW-1:0];
            end
        end
    end

    assign normal_rel = done[grant_id] || !req[grant_id];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt, hold_n;
    logic       tpulse_n;

    assign timeout_hit = (hold_cnt == HOLD_LAST);

    always_comb begin
        hold_n   = '0;
        tpulse_n = 1'b0;
        if (state == ST_GRANT) begin
            hold_n   = hold_cnt + 8'd1;
            // A coincident done/withdraw counts as an ordinary release.
            tpulse_n = timeout_hit && !normal_rel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            hold_cnt      <= hold_n;
            timeout_pulse <= tpulse_n;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        grant_id_n = grant_id;
        ptr_n      = ptr;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_n      = ST_GRANT;
                    grant_n      = '0;
                    grant_n[sel] = 1'b1;
                    grant_id_n   = sel;
                end
            end
            ST_GRANT: begin
                if (normal_rel || timeout_hit) begin
                    state_n = ST_IDLE;
                    grant_n = '0;
                    ptr_n   = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            grant_id <= grant_id_n;
            ptr      <= ptr_n;
        end
    end

    assign grant_valid = |grant;
    assign busy        = (state == ST_GRANT);

endmodule

// File: tb/tb_child_rr_arbiter.sv
// Bench for child_rr_arbiter: directed scenarios then random traffic against
// an integer-level reference model (timeout modelled when ARB_TIMEOUT_EN set).
module tb_child_rr_arbiter;

    localparam int N  = 5;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       busy;
    logic       timeout_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: owner < 0 means nobody holds the slot.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_last  = 0;
    int m_tp    = 0;

    child_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
        .busy(busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
        bit rel, to;
        int idx;
        if (!rs) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_last = 0; m_tp = 0;
        end else if (m_owner < 0) begin
            m_tp = 0;
            for (int j = 0; j < N; j++) begin
                idx = (m_ptr + j) % N;
                if (m_owner < 0 && r[idx]) m_owner = idx;
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_hold = 0;
            end
        end else begin
            rel = d[m_owner] || !r[m_owner];
`ifdef ARB_TIMEOUT_EN
            to = (m_hold == MH - 1);
`else
            to = 1'b0;
`endif
            if (rel || to) begin
                m_tp    = (to && !rel) ? 1 : 0;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_hold++;
                m_tp = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        chk("grant",         32'(grant),         32'(eg));
        chk("grant_valid",   32'(grant_valid),   32'(m_owner >= 0));
        chk("grant_id",      32'(grant_id),      32'(m_last));
        chk("busy",          32'(busy),          32'(m_owner >= 0));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
    endtask

    // One clock: compare against model, drive inputs, advance model on the edge.
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
        @(negedge clk);
        check_model();
        req = r; done = d; rst_n = rs;
        @(posedge clk);
        model_step(r, d, rs);
    endtask

    initial begin
        @(posedge clk);

        // Reset held with all requests asserted
        for (int i = 0; i < 3; i++) cycle(5'b11111, '0, 1'b0);
        #1; chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        cycle(5'b11111, '0, 1'b1);
        #1; chk("first_grant", 32'(grant), 32'h01);
        chk("first_id", 32'(grant_id), 32'h0);

        // Rotation with done two cycles after each grant
        for (int k = 0; k < 6; k++) begin
            cycle(5'b11111, '0, 1'b1);
            #1; chk("rot_id", 32'(grant_id), 32'(k % N));
            cycle(5'b11111, N'(1 << (k % N)), 1'b1);
            #1; chk("rot_gap", 32'(grant_valid), 32'h0);
            cycle(5'b11111, '0, 1'b1);
        end

        // Skip and wrap
        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b1);
        cycle(5'b00010, '0, 1'b1);
        cycle(5'b00010, 5'b00010, 1'b1);
        cycle(5'b10010, '0, 1'b1);
        #1; chk("skip_id", 32'(grant_id), 32'h4);
        cycle(5'b10010, 5'b10000, 1'b1);
        cycle(5'b10010, '0, 1'b1);
        #1; chk("wrap_id", 32'(grant_id), 32'h1);

        // Foreign done ignored, withdraw releases, ptr moves past owner
        cycle(5'b01000, '0, 1'b1);
        cycle(5'b01000, '0, 1'b1);
        #1; chk("own3", 32'(grant), 32'h08);
        cycle(5'b01000, 5'b00010, 1'b1);
        #1; chk("foreign_done", 32'(grant), 32'h08);
        cycle('0, '0, 1'b1);
        #1; chk("withdraw", 32'(grant), 32'h0);
        cycle(5'b10001, '0, 1'b1);
        #1; chk("ptr_after3", 32'(grant_id), 32'h4);

        // Timeout (forced release only with the feature built in)
        cycle(5'b00100, '0, 1'b1);
        cycle(5'b00100, '0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(5'b00100, '0, 1'b1);
`ifdef ARB_TIMEOUT_EN
        #1; chk("to_pulse", 32'(timeout_pulse), 32'h1);
        chk("to_drop", 32'(grant), 32'h0);
`else
        #1; chk("to_pulse", 32'(timeout_pulse), 32'h0);
        chk("to_hold", 32'(grant), 32'h04);
`endif
        cycle(5'b00100, '0, 1'b1);
        #1; chk("to_regrant", 32'(grant), 32'h04);
        chk("to_pulse_clr", 32'(timeout_pulse), 32'h0);

        // Reset in the middle of a grant
        cycle(5'b00010, '0, 1'b1);
        cycle(5'b00010, '0, 1'b1);
        #1; chk("rst_own1", 32'(grant_id), 32'h1);
        cycle(5'b00010, '0, 1'b0);
        #1; chk("rst_mid_grant", 32'(grant), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        cycle(5'b00010, '0, 1'b1);
        #1; chk("rst_regrant", 32'(grant_id), 32'h1);

        // Random traffic
        begin
            logic [N-1:0] r;
            logic [N-1:0] d;
            logic rs;
            r = '1;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 3) == 0) r = N'($urandom);
                d  = N'($urandom & $urandom & $urandom);
                rs = ($urandom_range(0, 63) != 0);
                cycle(r, d, rs);
            end
        end
        @(negedge clk);
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/child_rr_arbiter.md
Name: child_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource slot among the NUM_REQ child instances of a root module (five by default).
- Each child raises a request and gets an exclusive one-hot grant. The grant is held until the child signals done or withdraws its request.
- Sits beside the child instances inside the root module. It is the only block allowed to drive the per-child grant lines.

Parameters:
- NUM_REQ, 5, number of requesters (2..16).
- MAX_HOLD, 16, maximum grant duration in cycles before forced release (1..255). Used only when ARB_TIMEOUT_EN is defined.
- IDW, $clog2(NUM_REQ), width of grant_id (derived, not overridable).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_REQ  per-child request, level-sensitive.
- done  input  NUM_REQ  per-child release pulse; only the bit of the current owner is honoured.
- grant  output  NUM_REQ  one-hot grant, registered.
- grant_valid  output  1  high while any grant bit is high.
- grant_id  output  IDW  index of the current owner; holds the last owner when idle.
- busy  output  1  high in GRANT state.
- timeout_pulse  output  1  one-cycle pulse on forced release.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - grant=0, grant_valid=0, busy=0, grant_id=0, timeout_pulse=0.
  - Priority pointer ptr=0 and hold counter=0.
- Reset mid-grant drops the grant on that same edge. No done is required.
- States are IDLE and GRANT.
- IDLE:
  - If req!=0, select the first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - Next edge: grant[sel]=1, grant_id=sel, busy=1, hold counter=0, state goes to GRANT.
  - Latency from req rising to grant is 1 cycle.
  - If req==0, stay in IDLE with outputs low.
- GRANT: release occurs when any of the following holds at a clock edge:
  - done[grant_id]=1;
  - req[grant_id]=0 (withdrawn);
  - the hold counter equals MAX_HOLD-1 (timeout, only with ARB_TIMEOUT_EN).
- On release:
  - Next edge: grant=0, busy=0, ptr=(grant_id+1) mod NUM_REQ, state goes to IDLE.
  - There is always at least one IDLE cycle between consecutive grants, including back-to-back requests from different children.
- done bits of non-owners are ignored in every state. done in IDLE is ignored.
- Simultaneous done and timeout on the same edge: treated as a normal release, so timeout_pulse stays 0.
- Pointer wrap: owner NUM_REQ-1 sets ptr to 0.
- Fairness: with all requests continuously asserted, grants cycle 0,1,...,NUM_REQ-1,0,... Worst-case wait is (NUM_REQ-1)×(MAX_HOLD+1) cycles plus 1.
- grant is always one-hot or zero. grant_valid equals OR of grant, and busy equals grant_valid.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter increments each GRANT cycle.
  - When it reaches MAX_HOLD-1 with no done/withdraw, the arbiter force-releases.
  - timeout_pulse=1 for the cycle after that edge, coincident with grant dropping.
  - ptr advances as on a normal release.
- Not defined:
  - No counter is built and timeout_pulse is tied 0.
  - Grants last indefinitely until done or request withdrawal.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with req=5'b11111, then release → all outputs 0 during reset. First grant is grant=5'b00001, grant_id=0, one cycle after rst_n rises.
- Rotation: keep req=5'b11111 and pulse done of the owner 2 cycles after each grant → grant_id sequence 0,1,2,3,4,0, each grant separated by exactly 1 IDLE cycle.
- Skip and wrap: req=5'b10010, ptr=2 → grant_id=4. After done, next grant_id=1 (wrap past 0).
- Foreign done and withdraw: owner 3 is granted; pulse done[1] → grant unchanged. Drop req[3] → grant=0 next cycle and ptr=4.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=5'b00100 held with no done → grant high for 4 cycles, then timeout_pulse=1 for 1 cycle as grant falls. Re-grant to 2 after 1 IDLE cycle.
- Reset mid-grant: owner 1 granted, assert rst_n=0 for 1 cycle → grant=0 and busy=0 on that edge. After reset, with req=5'b00010, grant_id=1 (ptr reset to 0).
